// File: rtl/onchip_mem_avalon_master.sv
// onchip_mem_avalon_master
//   Avalon-MM master for a single-port on-chip RAM slave. The slave has no
//   waitrequest and a fixed read latency. The master runs one block command
//   at a time:
//   - write: words taken from a valid/ready stream are written to
//     consecutive addresses.
//   - read:  words read from consecutive addresses are returned through a
//     small buffer that supports backpressure.
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     cmd_valid/ready/write/addr/len/be
//                                     block command (accepted only in IDLE)
//     wr_data/valid/ready             write-data stream into the master
//     rd_data/valid/ready             read-data stream out of the master
//     done                            one-cycle pulse at block completion
//     avm_*                           registered Avalon-MM signals to the
//                                     RAM, plus readdata and clken
module onchip_mem_avalon_master #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [ADDR_W:0]       cmd_len,
  input  logic [DATA_W/8-1:0]   cmd_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic                  avm_clken
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0]       r_cur;
  logic [LEN_W-1:0]        r_rem;
  logic [BE_W-1:0]         r_be;

  logic [ADDR_W-1:0]       r_avm_address;
  logic [BE_W-1:0]         r_avm_be;
  logic                    r_avm_cs;
  logic                    r_avm_we;
  logic [DATA_W-1:0]       r_avm_wdata;

  logic [READ_LATENCY-1:0] r_pipe;
  logic [CNT_W-1:0]        r_outstanding;
  logic [DATA_W-1:0]       r_fifo [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;

  logic [LEN_W-1:0]        w_len;
  logic                    w_cmd_fire;
  logic                    w_wr_ready;
  logic                    w_wr_accept;
  logic                    w_rd_issue;
  logic                    w_credit_ok;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_cmd_ready;
  logic                    w_done;

  assign w_len       = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign w_cmd_fire  = cmd_valid & (r_state == S_IDLE);
  assign w_wr_accept = wr_valid & w_wr_ready;
  // Credit counts reads already decided but not yet returned, plus words
  // held in the buffer, so a returning word always has a free slot.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CNT_W+1)'(RD_FIFO_DEPTH);
  assign w_push      = r_pipe[READ_LATENCY-1];
  assign w_pop       = (r_count != '0) & rd_ready;

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_wr_ready  = 1'b0;
    w_rd_issue  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_len == '0)    w_next = S_DONE;
          else if (cmd_write) w_next = S_WRITE;
          else                w_next = S_READ;
        end
      end
      S_WRITE: begin
        w_wr_ready = (r_rem != '0);
        if (wr_valid && (r_rem == LEN_W'(1))) w_next = S_DONE;
      end
      S_READ: begin
        w_rd_issue = (r_rem != '0) & w_credit_ok;
        if (w_rd_issue && (r_rem == LEN_W'(1))) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_outstanding == '0) && (r_count == '0)) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Block bookkeeping and registered slave bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur         <= '0;
      r_rem         <= '0;
      r_be          <= '0;
      r_avm_address <= '0;
      r_avm_be      <= '0;
      r_avm_cs      <= 1'b0;
      r_avm_we      <= 1'b0;
      r_avm_wdata   <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_cur <= cmd_addr;
        r_rem <= w_len;
        r_be  <= cmd_be;
      end else if (w_wr_accept || w_rd_issue) begin
        r_cur <= r_cur + ADDR_W'(1);
        r_rem <= r_rem - LEN_W'(1);
      end
      r_avm_cs <= w_wr_accept | w_rd_issue;
      r_avm_we <= w_wr_accept;
      if (w_wr_accept) begin
        r_avm_address <= r_cur;
        r_avm_wdata   <= wr_data;
        r_avm_be      <= r_be;
      end else if (w_rd_issue) begin
        r_avm_address <= r_cur;
        r_avm_be      <= '1;
      end
    end
  end

  // A tag follows each slave read cycle. The word is captured when the tag
  // leaves the last stage, READ_LATENCY cycles after the read was presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe        <= '0;
      r_outstanding <= '0;
    end else begin
      r_pipe[0] <= r_avm_cs & ~r_avm_we;
      for (int unsigned i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      case ({w_rd_issue, w_push})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= avm_readdata;
  end

  assign cmd_ready      = w_cmd_ready;
  assign wr_ready       = w_wr_ready;
  assign done           = w_done;
  assign rd_valid       = (r_count != '0);
  assign rd_data        = r_fifo[r_rptr];
  assign avm_address    = r_avm_address;
  assign avm_byteenable = r_avm_be;
  assign avm_chipselect = r_avm_cs;
  assign avm_write      = r_avm_we;
  assign avm_writedata  = r_avm_wdata;
  assign avm_clken      = ~reset;

endmodule

// File: tb/tb_onchip_mem_avalon_master.sv
// Directed bench for onchip_mem_avalon_master with a behavioural 1024x32 RAM
// slave that has byteenable support and a read latency of one cycle.
module tb_onchip_mem_avalon_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [3:0]  cmd_be;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        done;
  logic [9:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_clken;

  always #5 clk = ~clk;

  onchip_mem_avalon_master #(
    .ADDR_W(10), .DATA_W(32), .READ_LATENCY(1), .RD_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_clken(avm_clken)
  );

  // RAM slave
  logic [31:0] smem [1024];
  logic [31:0] s_rdata;
  always @(posedge clk) begin
    if (avm_clken && avm_chipselect) begin
      if (avm_write) begin
        for (int b = 0; b < 4; b++)
          if (avm_byteenable[b]) smem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
      end else begin
        s_rdata <= smem[avm_address];
      end
    end
  end
  assign avm_readdata = s_rdata;

  // Bus / stream monitor, sampled on the falling edge
  int          cyc = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  int          n_rd_issue = 0;
  logic [9:0]  wa_q [$];
  logic [31:0] wd_q [$];
  int          wc_q [$];
  logic [31:0] rq [$];
  int          pc_q [$];

  always @(negedge clk) begin
    cyc++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (avm_chipselect && avm_write) begin
      wa_q.push_back(avm_address);
      wd_q.push_back(avm_writedata);
      wc_q.push_back(cyc);
    end
    if (avm_chipselect && !avm_write) n_rd_issue++;
    if (rd_valid && rd_ready) begin
      rq.push_back(rd_data);
      pc_q.push_back(cyc);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [10:0] l, input logic [3:0] be);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_be = be;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < budget) begin tick(1); k++; end
    chk({tag, "_done_once"}, 32'(n_done - d0), 32'd1);
  endtask

  task automatic wr_block(input string tag, input logic [9:0] a, input logic [10:0] l,
                          input logic [3:0] be, input logic [31:0] base);
    send_cmd(1'b1, a, l, be);
    for (int i = 0; i < int'(l); i++) begin
      chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      tick(1);
    end
    wr_valid = 1'b0;
    wait_done(tag, 10);
  endtask

  task automatic rd_block(input string tag, input logic [9:0] a, input logic [10:0] l);
    rd_ready = 1'b1;
    send_cmd(1'b0, a, l, 4'hF);
    wait_done(tag, 40 + int'(l));
  endtask

  initial begin
    int w0, r0, i0, d0, c0;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_be = '0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    tick(2);
    chk("rst_clken_low", 32'(avm_clken), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_clken", 32'(avm_clken), 32'd1);

    // 1: write 4 words at 0x010
    w0 = wa_q.size();
    wr_block("t1", 10'h010, 11'd4, 4'hF, 32'hA0);
    chk("t1_nwrites", 32'(wa_q.size() - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 32'(wa_q[w0+i]), 32'h010 + 32'(i));
      chk("t1_data", wd_q[w0+i], 32'hA0 + 32'(i));
      chk("t1_consec", 32'(wc_q[w0+i] - wc_q[w0]), 32'(i));
    end
    chk("t1_idle", 32'(cmd_ready), 32'd1);

    // 2: read back 4 words; first rd_valid 3 edges after handshake
    r0 = rq.size();
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 11'd4, 4'hF);
    c0 = cyc;
    wait_done("t2", 40);
    chk("t2_npops", 32'(rq.size() - r0), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_data", rq[r0+i], 32'hA0 + 32'(i));
    chk("t2_first_lat", 32'(pc_q[r0] - c0), 32'd4);
    chk("t2_b2b", 32'(pc_q[r0+3] - pc_q[r0]), 32'd3);
    chk("t2_done_after_pop", 32'(done_cyc - pc_q[r0+3]), 32'd2);

    // 3: write across the top of the address space, read back
    w0 = wa_q.size();
    wr_block("t3w", 10'h3FE, 11'd3, 4'hF, 32'hB0);
    chk("t3_addr0", 32'(wa_q[w0]),   32'h3FE);
    chk("t3_addr1", 32'(wa_q[w0+1]), 32'h3FF);
    chk("t3_addr2", 32'(wa_q[w0+2]), 32'h000);
    r0 = rq.size();
    rd_block("t3r", 10'h3FE, 11'd3);
    chk("t3_npops", 32'(rq.size() - r0), 32'd3);
    for (int i = 0; i < 3; i++) chk("t3_data", rq[r0+i], 32'hB0 + 32'(i));

    // 4: 16-word read under backpressure
    wr_block("t4w", 10'h100, 11'd16, 4'hF, 32'hC00);
    rd_ready = 1'b0;
    r0 = rq.size();
    i0 = n_rd_issue;
    send_cmd(1'b0, 10'h100, 11'd16, 4'hF);
    tick(20);
    chk("t4_issues_stalled", 32'(n_rd_issue - i0), 32'd4);
    chk("t4_rd_valid", 32'(rd_valid), 32'd1);
    chk("t4_head_hold", rd_data, 32'hC00);
    rd_ready = 1'b1;
    wait_done("t4r", 80);
    chk("t4_npops", 32'(rq.size() - r0), 32'd16);
    for (int i = 0; i < 16; i++) chk("t4_data", rq[r0+i], 32'hC00 + 32'(i));

    // 5: partial byteenable merge, then a zero-length command
    wr_block("t5a", 10'h200, 11'd1, 4'hF, 32'h11223344);
    wr_block("t5b", 10'h200, 11'd1, 4'b0011, 32'hDEADBEEF);
    r0 = rq.size();
    rd_block("t5r", 10'h200, 11'd1);
    chk("t5_merge", rq[r0], 32'h1122BEEF);
    w0 = wa_q.size();
    i0 = n_rd_issue;
    d0 = n_done;
    send_cmd(1'b1, 10'h050, 11'd0, 4'hF);
    chk("t5_len0_done", 32'(done), 32'd1);
    tick(1);
    chk("t5_len0_done_end", 32'(done), 32'd0);
    chk("t5_len0_idle", 32'(cmd_ready), 32'd1);
    tick(3);
    chk("t5_len0_nowr", 32'(wa_q.size() - w0), 32'd0);
    chk("t5_len0_nord", 32'(n_rd_issue - i0), 32'd0);
    chk("t5_len0_ndone", 32'(n_done - d0), 32'd1);

    // Oversized length clamps to the full 1024-word space
    r0 = rq.size();
    i0 = n_rd_issue;
    rd_block("clamp", 10'h000, 11'h7FF);
    chk("clamp_npops", 32'(rq.size() - r0), 32'd1024);
    chk("clamp_nissue", 32'(n_rd_issue - i0), 32'd1024);

    // 6: reset with two reads outstanding
    rd_ready = 1'b0;
    d0 = n_done;
    send_cmd(1'b0, 10'h100, 11'd8, 4'hF);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_idle", 32'(cmd_ready), 32'd1);
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_cs", 32'(avm_chipselect), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    tick(4);
    chk("t6_rd_valid_late", 32'(rd_valid), 32'd0);
    chk("t6_no_done", 32'(n_done - d0), 32'd0);
    r0 = rq.size();
    rd_block("t6r", 10'h100, 11'd2);
    chk("t6_post_npops", 32'(rq.size() - r0), 32'd2);
    chk("t6_post_d0", rq[r0],   32'hC00);
    chk("t6_post_d1", rq[r0+1], 32'hC01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
